// File: rtl/simd_pkg.sv
// Shared SIMD constants and types for the operand-loading path.
// Holds the lane geometry, a lane-sized element type and the transpose writer FSM states.
package simd_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 4;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } tbw_state_t;

endpackage

// File: rtl/transpose_band_writer_if.sv
// Row-major input stream plus operand BRAM write port of the transpose band writer.
// The slave modport is the writer itself; the master modport is its environment.
interface transpose_band_writer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_W     = 8
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic                  bram_we;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  bram_addr,
    input  bram_wdata,
    input  bram_we
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output bram_addr,
    output bram_wdata,
    output bram_we
  );

endinterface

// File: rtl/lane_column_gather.sv
// Combinational column gather: picks lane j from each buffered row word and packs them
// into one column word, row 0 landing in the most significant lane.
module lane_column_gather #(
  parameter int  DATA_WIDTH = 128,
  parameter int  LANE_W     = 32,
  localparam int ROWS       = DATA_WIDTH / LANE_W,
  localparam int JW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [DATA_WIDTH-1:0] words [ROWS],
  input  logic [JW-1:0]         lane_sel,
  output logic [DATA_WIDTH-1:0] column
);

  always_comb begin
    column = '0;
    for (int r = 0; r < ROWS; r++) begin
      column[DATA_WIDTH-1-r*LANE_W -: LANE_W] =
        words[r][DATA_WIDTH-1-int'(lane_sel)*LANE_W -: LANE_W];
    end
  end

endmodule

// File: rtl/transpose_band_writer.sv
// Buffers one band of row-major matrix words, then drains it into the operand BRAM as
// transposed column words so the SIMD core can read a matrix column at consecutive addresses.
module transpose_band_writer #(
  parameter int  DATA_WIDTH = 128,
  parameter int  LANE_W     = 32,
  parameter int  MAT_DIM    = 8,
  parameter int  DEPTH      = 256,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  transpose_band_writer_if.slave bus,
  output logic                  busy,
  output logic                  done
);

  import simd_pkg::*;

  localparam int NLANE = DATA_WIDTH / LANE_W;
  localparam int KPR   = MAT_DIM / NLANE;
  localparam int RW    = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int CW    = (KPR > 1) ? $clog2(KPR) : 1;
  localparam int WW    = $clog2(MAT_DIM);

  tbw_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         chunk_q, chunk_d;
  logic [CW-1:0]         rb_q, rb_d;
  logic [WW-1:0]         w_q, w_d;
  logic [DATA_WIDTH-1:0] band_q [NLANE][KPR];
  logic [DATA_WIDTH-1:0] band_d [NLANE][KPR];

  logic [DATA_WIDTH-1:0] gather_words [NLANE];
  logic [DATA_WIDTH-1:0] gather_col;
  logic [RW-1:0]         lane_sel;
  logic [CW-1:0]         k_sel;
  int                    addr_sum;

  // Write index w selects chunk k = w / NLANE of every buffered row and lane j = w % NLANE.
  always_comb begin
    k_sel    = CW'(w_q >> RW);
    lane_sel = w_q[RW-1:0];
    for (int r = 0; r < NLANE; r++) begin
      gather_words[r] = band_q[r][k_sel];
    end
  end

  lane_column_gather #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_W     (LANE_W)
  ) u_gather (
    .words    (gather_words),
    .lane_sel (lane_sel),
    .column   (gather_col)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    row_d    = row_q;
    chunk_d  = chunk_q;
    rb_d     = rb_q;
    w_d      = w_q;
    band_d   = band_q;
    addr_sum = 0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          row_d   = '0;
          chunk_d = '0;
          rb_d    = '0;
          w_d     = '0;
          busy_d  = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          band_d[row_q][chunk_q] = bus.in_data;
          if (chunk_q == CW'(KPR - 1)) begin
            chunk_d = '0;
            if (row_q == RW'(NLANE - 1)) begin
              row_d   = '0;
              w_d     = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            chunk_d = chunk_q + CW'(1);
          end
        end
      end

      // Column c of band rb lands at base + c*KPR + rb; addresses wrap modulo DEPTH.
      DRAIN: begin
        addr_sum = int'(base_q) + int'(w_q) * KPR + int'(rb_q);
        addr_d   = ADDR_W'(addr_sum % DEPTH);
        wdata_d  = gather_col;
        we_d     = 1'b1;
        if (w_q == WW'(MAT_DIM - 1)) begin
          w_d = '0;
          if (rb_q == CW'(KPR - 1)) begin
            state_d = DONE;
          end else begin
            rb_d    = rb_q + CW'(1);
            state_d = FILL;
          end
        end else begin
          w_d = w_q + WW'(1);
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Holding in_ready low while the final column write is still on the port keeps them exclusive.
    in_ready_d = (state_d == FILL) && !we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_q      <= '0;
      chunk_q    <= '0;
      rb_q       <= '0;
      w_q        <= '0;
      for (int r = 0; r < NLANE; r++) begin
        for (int k = 0; k < KPR; k++) begin
          band_q[r][k] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      row_q      <= row_d;
      chunk_q    <= chunk_d;
      rb_q       <= rb_d;
      w_q        <= w_d;
      band_q     <= band_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.bram_we    = we_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_transpose_band_writer.sv
// Scoreboard bench for transpose_band_writer: every load pushes its expected column writes,
// a negedge monitor logs what the BRAM port actually receives, and each test pops and compares.
module tb_transpose_band_writer;

  localparam int DW      = 128;
  localparam int LW      = 32;
  localparam int MD      = 8;
  localparam int DEPTH   = 256;
  localparam int AW      = 8;
  localparam int KPR     = 2;
  localparam int NWORDS  = 16;
  localparam int NWRITES = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;

  transpose_band_writer_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  transpose_band_writer #(
    .DATA_WIDTH (DW),
    .LANE_W     (LW),
    .MAT_DIM    (MD),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  wr_t        wr_q [$];
  wr_t        exp_q [$];
  logic [DW-1:0] mem [DEPTH];
  int         wcount [DEPTH];
  int         done_count  = 0;
  int         done_cyc    = 0;
  int         last_wr_cyc = 0;
  int         overlap_cnt = 0;
  logic       busy_at_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.bram_we === 1'b1) begin
      wr_q.push_back('{bus.bram_addr, bus.bram_wdata, cyc});
      mem[bus.bram_addr]    = bus.bram_wdata;
      wcount[bus.bram_addr] = wcount[bus.bram_addr] + 1;
      last_wr_cyc           = cyc;
      if (bus.in_ready === 1'b1) overlap_cnt = overlap_cnt + 1;
    end
    if (done === 1'b1) begin
      done_count   = done_count + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  // Matrix element (r, c) holds r*MD + c + 1, so the test matrix counts 1..0x40 row-major.
  function automatic logic [LW-1:0] elem(input int r, input int c);
    return LW'(r * MD + c + 1);
  endfunction

  function automatic logic [DW-1:0] in_word(input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[DW-1-j*LW -: LW] = elem(idx / KPR, 4 * (idx % KPR) + j);
    return w;
  endfunction

  function automatic logic [DW-1:0] col_word(input int rb, input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[DW-1-i*LW -: LW] = elem(4 * rb + i, c);
    return w;
  endfunction

  task automatic push_expected(input logic [AW-1:0] base);
    wr_t e;
    exp_q.delete();
    for (int rb = 0; rb < MD / 4; rb++) begin
      for (int c = 0; c < MD; c++) begin
        e.addr = AW'((int'(base) + c * KPR + rb) % DEPTH);
        e.data = col_word(rb, c);
        e.cyc  = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_log();
    wr_q.delete();
    overlap_cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]    = '0;
      wcount[a] = 0;
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 8'h5A;
  endtask

  task automatic feed_words(input int first, input int n, input int duty, output bit timed_out);
    int idx;
    int guard;
    bit v;
    idx   = first;
    guard = 0;
    while (idx < first + n && guard < 2000) begin
      @(negedge clk);
      guard = guard + 1;
      v = ($urandom_range(0, 99) < duty);
      bus.in_valid = v;
      bus.in_data  = v ? in_word(idx) : {$urandom, $urandom, $urandom, $urandom};
      if (v && bus.in_ready === 1'b1) idx = idx + 1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    timed_out = (idx < first + n);
  endtask

  task automatic wait_done(input int start_count, output bit timed_out);
    int guard;
    guard = 0;
    while (done_count == start_count && guard < 3000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    timed_out = (done_count == start_count);
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int duty, output bit feed_to, output bit done_to);
    int dc;
    dc = done_count;
    pulse_start(base);
    fork
      feed_words(0, NWORDS, duty, feed_to);
      wait_done(dc, done_to);
    join
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    vectors++; if (bus.bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we got %0b want 0", bus.bram_we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    vectors++; if (bus.bram_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_addr got %0h want 0", bus.bram_addr); end
    vectors++; if (bus.bram_wdata !== '0) begin miscompares++; $display("[TB] FAIL reset_wdata got %0h want 0", bus.bram_wdata); end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_in_ready got %0b want 0", bus.in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got %0b want 0", busy); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    bit  fto, dto;
    int  dc;
    wr_t e, g;
    clear_log();
    push_expected(8'h00);
    dc = done_count;
    run_load(8'h00, 100, fto, dto);
    vectors++; if (fto || dto) begin miscompares++; $display("[TB] FAIL basic_timeout got feed=%0b done=%0b want 0 0", fto, dto); end
    vectors++; if (wr_q.size() != NWRITES) begin miscompares++; $display("[TB] FAIL basic_count got %0d want %0d", wr_q.size(), NWRITES); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (wr_q.size() == 0) begin miscompares++; $display("[TB] FAIL basic_missing addr %0h got none want %0h", e.addr, e.data); end
      else begin
        g = wr_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) begin miscompares++; $display("[TB] FAIL basic_write got %0h:%0h want %0h:%0h", g.addr, g.data, e.addr, e.data); end
      end
    end
    vectors++; if (mem[0] !== 128'h00000001_00000009_00000011_00000019) begin miscompares++; $display("[TB] FAIL basic_addr0 got %0h want 1,9,11,19", mem[0]); end
    vectors++; if (mem[1] !== 128'h00000021_00000029_00000031_00000039) begin miscompares++; $display("[TB] FAIL basic_addr1 got %0h want 21,29,31,39", mem[1]); end
    vectors++; if (mem[2] !== 128'h00000002_0000000A_00000012_0000001A) begin miscompares++; $display("[TB] FAIL basic_addr2 got %0h want 2,A,12,1A", mem[2]); end
    vectors++; if (mem[15] !== 128'h00000028_00000030_00000038_00000040) begin miscompares++; $display("[TB] FAIL basic_addr15 got %0h want 28,30,38,40", mem[15]); end
    vectors++; if (done_count - dc != 1) begin miscompares++; $display("[TB] FAIL basic_done_pulses got %0d want 1", done_count - dc); end
    vectors++; if (done_cyc != last_wr_cyc + 1) begin miscompares++; $display("[TB] FAIL basic_done_timing got cycle %0d want %0d", done_cyc, last_wr_cyc + 1); end
    vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_at_done got %0b want 0", busy_at_done); end
    vectors++; if (overlap_cnt != 0) begin miscompares++; $display("[TB] FAIL basic_we_ready_overlap got %0d want 0", overlap_cnt); end
  endtask

  task automatic test_random_duty();
    bit  fto, dto;
    int  bad;
    wr_t e, g;
    clear_log();
    push_expected(8'h00);
    run_load(8'h00, 30, fto, dto);
    vectors++; if (fto || dto) begin miscompares++; $display("[TB] FAIL duty_timeout got feed=%0b done=%0b want 0 0", fto, dto); end
    vectors++; if (wr_q.size() != NWRITES) begin miscompares++; $display("[TB] FAIL duty_count got %0d want %0d", wr_q.size(), NWRITES); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (wr_q.size() == 0) begin miscompares++; $display("[TB] FAIL duty_missing addr %0h got none want %0h", e.addr, e.data); end
      else begin
        g = wr_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) begin miscompares++; $display("[TB] FAIL duty_write got %0h:%0h want %0h:%0h", g.addr, g.data, e.addr, e.data); end
      end
    end
    bad = 0;
    for (int a = 0; a < NWRITES; a++) if (wcount[a] != 1) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL duty_write_once got %0d bad addresses want 0", bad); end
    vectors++; if (overlap_cnt != 0) begin miscompares++; $display("[TB] FAIL duty_we_ready_overlap got %0d want 0", overlap_cnt); end
  endtask

  task automatic test_wrap();
    bit  fto, dto;
    wr_t e, g;
    clear_log();
    push_expected(8'hF8);
    run_load(8'hF8, 100, fto, dto);
    vectors++; if (fto || dto) begin miscompares++; $display("[TB] FAIL wrap_timeout got feed=%0b done=%0b want 0 0", fto, dto); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (wr_q.size() == 0) begin miscompares++; $display("[TB] FAIL wrap_missing addr %0h got none want %0h", e.addr, e.data); end
      else begin
        g = wr_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) begin miscompares++; $display("[TB] FAIL wrap_write got %0h:%0h want %0h:%0h", g.addr, g.data, e.addr, e.data); end
      end
    end
    vectors++; if (mem[8'hF8] !== 128'h00000001_00000009_00000011_00000019) begin miscompares++; $display("[TB] FAIL wrap_addrF8 got %0h want 1,9,11,19", mem[8'hF8]); end
    vectors++; if (mem[8'hFA] !== 128'h00000002_0000000A_00000012_0000001A) begin miscompares++; $display("[TB] FAIL wrap_addrFA got %0h want 2,A,12,1A", mem[8'hFA]); end
    // Offset 8 from 0xF8 wraps to 0x00 and carries column 4 of band 0.
    vectors++; if (mem[8'h00] !== 128'h00000005_0000000D_00000015_0000001D) begin miscompares++; $display("[TB] FAIL wrap_addr00 got %0h want 5,D,15,1D", mem[8'h00]); end
    vectors++; if (wcount[8'h08] != 0) begin miscompares++; $display("[TB] FAIL wrap_addr08_untouched got %0d writes want 0", wcount[8'h08]); end
  endtask

  task automatic test_start_ignored();
    bit  fto, dto;
    int  dc, g2, stray;
    wr_t e, g;
    clear_log();
    push_expected(8'h10);
    dc = done_count;
    pulse_start(8'h10);
    fork
      feed_words(0, NWORDS, 100, fto);
      wait_done(dc, dto);
      begin
        g2 = 0;
        while (wr_q.size() < 2 && g2 < 2000) begin @(negedge clk); g2++; end
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h80;
        @(negedge clk);
        start     = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    vectors++; if (fto || dto) begin miscompares++; $display("[TB] FAIL ignore_timeout got feed=%0b done=%0b want 0 0", fto, dto); end
    vectors++; if (done_count - dc != 1) begin miscompares++; $display("[TB] FAIL ignore_done_pulses got %0d want 1", done_count - dc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_busy_after got %0b want 0", busy); end
    stray = 0;
    for (int a = 8'h80; a < 8'h90; a++) stray += wcount[a];
    vectors++; if (stray != 0) begin miscompares++; $display("[TB] FAIL ignore_stray_writes got %0d want 0", stray); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (wr_q.size() == 0) begin miscompares++; $display("[TB] FAIL ignore_missing addr %0h got none want %0h", e.addr, e.data); end
      else begin
        g = wr_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) begin miscompares++; $display("[TB] FAIL ignore_write got %0h:%0h want %0h:%0h", g.addr, g.data, e.addr, e.data); end
      end
    end
    vectors++; if (wr_q.size() != 0) begin miscompares++; $display("[TB] FAIL ignore_extra_writes got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_reset_mid_drain();
    bit  fto, dto;
    int  n, guard;
    wr_t e, g;
    clear_log();
    pulse_start(8'h00);
    feed_words(0, NWORDS / 2, 100, fto);
    n = 0;
    guard = 0;
    while (n < 3 && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
      if (bus.bram_we === 1'b1) n++;
    end
    vectors++; if (fto || n < 3) begin miscompares++; $display("[TB] FAIL abort_reach_drain got %0d writes want 3", n); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.bram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_we got %0b want 0", bus.bram_we); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_in_ready got %0b want 0", bus.in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %0b want 0", busy); end
    vectors++; if (bus.bram_addr !== 8'h00 || bus.bram_wdata !== '0) begin miscompares++; $display("[TB] FAIL abort_bus got %0h:%0h want 0:0", bus.bram_addr, bus.bram_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    push_expected(8'h20);
    run_load(8'h20, 100, fto, dto);
    vectors++; if (fto || dto) begin miscompares++; $display("[TB] FAIL reload_timeout got feed=%0b done=%0b want 0 0", fto, dto); end
    vectors++; if (wr_q.size() != NWRITES) begin miscompares++; $display("[TB] FAIL reload_count got %0d want %0d", wr_q.size(), NWRITES); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (wr_q.size() == 0) begin miscompares++; $display("[TB] FAIL reload_missing addr %0h got none want %0h", e.addr, e.data); end
      else begin
        g = wr_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) begin miscompares++; $display("[TB] FAIL reload_write got %0h:%0h want %0h:%0h", g.addr, g.data, e.addr, e.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit fto, dto;
    int want, gaps;
    clear_log();
    run_load(8'h00, 100, fto, dto);
    vectors++; if (fto || dto || wr_q.size() < NWRITES) begin miscompares++; $display("[TB] FAIL order_run got %0d writes want %0d", wr_q.size(), NWRITES); end
    else begin
      gaps = 0;
      for (int i = 0; i < NWRITES; i++) begin
        want = (i < 8) ? 2 * i : 2 * (i - 8) + 1;
        vectors++;
        if (wr_q[i].addr !== AW'(want)) begin miscompares++; $display("[TB] FAIL order_addr[%0d] got %0h want %0h", i, wr_q[i].addr, want); end
        if (i % 8 != 0 && wr_q[i].cyc != wr_q[i-1].cyc + 1) gaps++;
      end
      vectors++; if (gaps != 0) begin miscompares++; $display("[TB] FAIL order_consecutive got %0d gaps want 0", gaps); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_random_duty();
    test_wrap();
    test_start_ignored();
    test_reset_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
